// File: rtl/dmem_arb_pkg.sv
// Shared types and default sizing for the data-memory arbiter.
package dmem_arb_pkg;

    typedef enum logic {
        OWN_CPU = 1'b0,
        OWN_DMA = 1'b1
    } owner_t;

    localparam int DEF_ADDR_W    = 32;
    localparam int DEF_DATA_W    = 32;
    localparam int DEF_MAX_WAIT  = 4;
    localparam int DEF_BURST_MAX = 8;

endpackage

// File: rtl/arb_counter.sv
// Up-counter with synchronous clear (priority) and count enable.
module arb_counter
    import dmem_arb_pkg::*;
#(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] cnt
);

    always_ff @(posedge clk) begin
        if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + W'(1);
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares dmem between the CPU data port (default owner) and a DMA/debug master,
// with bounded DMA starvation and a capped DMA burst length.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int DATA_W    = DEF_DATA_W,
    parameter int MAX_WAIT  = DEF_MAX_WAIT,
    parameter int BURST_MAX = DEF_BURST_MAX
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_memwrite,
    input  logic [ADDR_W-1:0] cpu_dataadr,
    input  logic [DATA_W-1:0] cpu_writedata,
    output logic [DATA_W-1:0] cpu_readdata,
    output logic              cpu_stall,
    input  logic              dma_req,
    input  logic              dma_we,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic [DATA_W-1:0] dma_wdata,
    output logic              dma_gnt,
    output logic [DATA_W-1:0] dma_rdata,
    output logic              dma_rvalid,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int WAIT_W = $clog2(MAX_WAIT) + 1;
    localparam int BEAT_W = $clog2(BURST_MAX) + 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MAX_WAIT - 1);
    localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(BURST_MAX - 1);

    owner_t            owner;
    owner_t            owner_nxt;
    logic [WAIT_W-1:0] wait_cnt;
    logic [BEAT_W-1:0] beat_cnt;
    logic              wait_clr;
    logic              wait_en;
    logic              beat_clr;
    logic              beat_en;
    logic              contended;
    logic              dma_take;
    logic              burst_done;
    logic              rd_acc;
    logic [DATA_W-1:0] rdata_p1;
    logic              vld_p1;

    assign contended  = cpu_req & dma_req;
    assign dma_take   = dma_req & (~cpu_req | (wait_cnt == WAIT_LAST));
    assign burst_done = dma_req & (beat_cnt == BEAT_LAST);
    assign rd_acc     = (owner == OWN_DMA) & dma_req & ~dma_we;

    arb_counter #(.W(WAIT_W)) u_wait_cnt (
        .clk (clk),
        .clr (wait_clr),
        .en  (wait_en),
        .cnt (wait_cnt)
    );

    arb_counter #(.W(BEAT_W)) u_beat_cnt (
        .clk (clk),
        .clr (beat_clr),
        .en  (beat_en),
        .cnt (beat_cnt)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            owner <= OWN_CPU;
        end else begin
            owner <= owner_nxt;
        end
    end

    // wait_en is only raised while below WAIT_LAST, so wait_cnt saturates there.
    always_comb begin
        owner_nxt = owner;
        wait_clr  = reset;
        wait_en   = 1'b0;
        beat_clr  = reset;
        beat_en   = 1'b0;
        unique case (owner)
            OWN_CPU: begin
                if (dma_take) begin
                    owner_nxt = OWN_DMA;
                    wait_clr  = 1'b1;
                    beat_clr  = 1'b1;
                end else begin
                    wait_en = contended;
                end
            end
            OWN_DMA: begin
                beat_en = dma_req;
                if (!dma_req || burst_done) begin
                    owner_nxt = OWN_CPU;
                end
            end
        endcase
    end

    always_comb begin
        mem_addr     = cpu_dataadr;
        mem_wdata    = cpu_writedata;
        mem_we       = cpu_req & cpu_memwrite;
        cpu_readdata = mem_rdata;
        cpu_stall    = 1'b0;
        dma_gnt      = 1'b0;
        if (owner == OWN_DMA) begin
            mem_addr     = dma_addr;
            mem_wdata    = dma_wdata;
            mem_we       = dma_req & dma_we;
            cpu_readdata = '0;
            cpu_stall    = cpu_req;
            dma_gnt      = 1'b1;
        end
        if (reset) begin
            mem_we = 1'b0;
        end
    end

    // p0 -> p1: DMA read data captured on the accepting edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            vld_p1   <= 1'b0;
            rdata_p1 <= '0;
        end else begin
            vld_p1 <= rd_acc;
            if (rd_acc) begin
                rdata_p1 <= mem_rdata;
            end
        end
    end

    assign dma_rvalid = vld_p1;
    assign dma_rdata  = rdata_p1;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Randomized and directed bench for dmem_arbiter against a behavioural ownership model.
module tb_dmem_arbiter;

    localparam int MW = 4;
    localparam int BM = 8;

    logic        clk;
    logic        reset;
    logic        cpu_req;
    logic        cpu_memwrite;
    logic [31:0] cpu_dataadr;
    logic [31:0] cpu_writedata;
    logic [31:0] cpu_readdata;
    logic        cpu_stall;
    logic        dma_req;
    logic        dma_we;
    logic [31:0] dma_addr;
    logic [31:0] dma_wdata;
    logic        dma_gnt;
    logic [31:0] dma_rdata;
    logic        dma_rvalid;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    int total = 0;
    int bad   = 0;

    logic [31:0] dmem    [0:255] = '{default: '0};
    logic [31:0] ref_mem [0:255] = '{default: '0};

    bit          armed   = 0;
    bit          m_dma   = 0;
    int          m_wait  = 0;
    int          m_beats = 0;
    bit          m_rv    = 0;
    logic [31:0] m_rd    = '0;

    dmem_arbiter #(
        .ADDR_W    (32),
        .DATA_W    (32),
        .MAX_WAIT  (MW),
        .BURST_MAX (BM)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .cpu_req       (cpu_req),
        .cpu_memwrite  (cpu_memwrite),
        .cpu_dataadr   (cpu_dataadr),
        .cpu_writedata (cpu_writedata),
        .cpu_readdata  (cpu_readdata),
        .cpu_stall     (cpu_stall),
        .dma_req       (dma_req),
        .dma_we        (dma_we),
        .dma_addr      (dma_addr),
        .dma_wdata     (dma_wdata),
        .dma_gnt       (dma_gnt),
        .dma_rdata     (dma_rdata),
        .dma_rvalid    (dma_rvalid),
        .mem_we        (mem_we),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .mem_rdata     (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Environment data memory: asynchronous read, write on the edge.
    assign mem_rdata = dmem[mem_addr[9:2]];
    always @(posedge clk) begin
        if (mem_we === 1'b1) dmem[mem_addr[9:2]] <= mem_wdata;
    end

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b want %b at %0t", name, act, exp, $time);
        end
    endtask

    // Ownership model: who owns memory, how long DMA has been blocked, beats taken.
    always @(posedge clk) begin
        if (reset) begin
            armed   = 1;
            m_dma   = 0;
            m_wait  = 0;
            m_beats = 0;
            m_rv    = 0;
            m_rd    = '0;
        end else if (armed) begin
            if (m_dma) begin
                m_rv = dma_req && !dma_we;
                if (m_rv) m_rd = ref_mem[dma_addr[9:2]];
                if (dma_req && dma_we) ref_mem[dma_addr[9:2]] = dma_wdata;
                if (dma_req) m_beats = m_beats + 1;
                if (!dma_req || m_beats == BM) m_dma = 0;
            end else begin
                m_rv = 0;
                if (cpu_req && cpu_memwrite) ref_mem[cpu_dataadr[9:2]] = cpu_writedata;
                if (dma_req && (!cpu_req || m_wait == MW - 1)) begin
                    m_dma   = 1;
                    m_wait  = 0;
                    m_beats = 0;
                end else if (dma_req && cpu_req) begin
                    m_wait = m_wait + 1;
                end
            end
        end
    end

    always @(negedge clk) begin
        logic [31:0] ea, ewd, erd;
        logic        ewe, est, eg;
        if (armed) begin
            if (m_dma) begin
                ea = dma_addr; ewd = dma_wdata; ewe = dma_req && dma_we;
                est = cpu_req; eg = 1'b1; erd = '0;
            end else begin
                ea = cpu_dataadr; ewd = cpu_writedata; ewe = cpu_req && cpu_memwrite;
                est = 1'b0; eg = 1'b0; erd = ref_mem[cpu_dataadr[9:2]];
            end
            if (reset) ewe = 1'b0;
            chk1("mem_we", mem_we, ewe);
            chk32("mem_addr", mem_addr, ea);
            if (ewe) chk32("mem_wdata", mem_wdata, ewd);
            chk32("cpu_readdata", cpu_readdata, erd);
            chk1("cpu_stall", cpu_stall, est);
            chk1("dma_gnt", dma_gnt, eg);
            chk1("dma_rvalid", dma_rvalid, m_rv);
            chk32("dma_rdata", dma_rdata, m_rd);
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        cpu_req = 0; cpu_memwrite = 0; dma_req = 0; dma_we = 0;
    endtask

    initial begin
        int g;
        bit gs [0:19];
        int dens_c, dens_d;
        reset = 1; idle();
        cpu_dataadr = '0; cpu_writedata = '0; dma_addr = '0; dma_wdata = '0;
        cyc(); cyc();
        reset = 0;
        #1;
        chk1("rst_gnt", dma_gnt, 1'b0);
        chk1("rst_rvalid", dma_rvalid, 1'b0);
        chk32("rst_rdata", dma_rdata, 32'h0);
        chk1("rst_stall", cpu_stall, 1'b0);
        cyc();

        // CPU only: store then load.
        cpu_req = 1; cpu_memwrite = 1; cpu_dataadr = 32'h40; cpu_writedata = 32'hDEADBEEF;
        #1 chk1("cpu_st_we", mem_we, 1'b1);
        chk1("cpu_st_stall", cpu_stall, 1'b0);
        cyc();
        cpu_memwrite = 0;
        #1 chk32("cpu_ld_data", cpu_readdata, 32'hDEADBEEF);
        chk1("cpu_ld_stall", cpu_stall, 1'b0);
        cyc();

        // Idle CPU, DMA burst of three writes.
        idle();
        dma_req = 1; dma_we = 1; dma_addr = 32'h10; dma_wdata = 32'hA0;
        #1 chk1("bw_decide_gnt", dma_gnt, 1'b0);
        cyc();
        for (int i = 0; i < 3; i++) begin
            dma_addr = 32'(32'h10 + i * 4); dma_wdata = 32'(32'hA0 + i);
            #1 chk1("bw_gnt", dma_gnt, 1'b1);
            chk1("bw_we", mem_we, 1'b1);
            chk32("bw_addr", mem_addr, 32'(32'h10 + i * 4));
            cyc();
        end
        dma_req = 0;
        #1 chk1("bw_drop_we", mem_we, 1'b0);
        cyc();
        #1 chk1("bw_back_cpu", dma_gnt, 1'b0);
        cyc();

        // Preload via CPU stores, then two back-to-back DMA reads.
        cpu_req = 1; cpu_memwrite = 1; cpu_dataadr = 32'h80; cpu_writedata = 32'h11111111;
        cyc();
        cpu_dataadr = 32'h84; cpu_writedata = 32'h22222222;
        cyc();
        idle();
        dma_req = 1; dma_we = 0; dma_addr = 32'h80;
        cyc();
        #1 chk1("rd_gnt0", dma_gnt, 1'b1);
        cyc();
        dma_addr = 32'h84;
        #1 chk1("rd_rv0", dma_rvalid, 1'b1);
        chk32("rd_data0", dma_rdata, 32'h11111111);
        cyc();
        dma_req = 0;
        #1 chk1("rd_rv1", dma_rvalid, 1'b1);
        chk32("rd_data1", dma_rdata, 32'h22222222);
        cyc();
        #1 chk1("rd_rv_end", dma_rvalid, 1'b0);
        cyc();

        // Starvation: continuous CPU loads, DMA forced in on cycle 5.
        cpu_req = 1; cpu_memwrite = 0; cpu_dataadr = 32'h40;
        dma_req = 1; dma_we = 1; dma_addr = 32'h20; dma_wdata = 32'hCAFE0000;
        for (int i = 1; i <= 5; i++) begin
            #1 chk1("starve_gnt", dma_gnt, i == 5);
            chk1("starve_stall", cpu_stall, i == 5);
            chk32("starve_rd", cpu_readdata, (i == 5) ? 32'h0 : 32'hDEADBEEF);
            cyc();
        end
        dma_req = 0;
        #1 chk1("starve_exit_stall", cpu_stall, 1'b1);
        chk1("starve_exit_we", mem_we, 1'b0);
        cyc();
        #1 chk1("starve_cpu_back", cpu_stall, 1'b0);
        cyc();

        // Burst cap: DMA held for 20 cycles with CPU idle.
        idle();
        g = 0;
        for (int i = 0; i < 20; i++) begin
            dma_req = 1; dma_we = 1; dma_addr = 32'(32'h100 + i * 4); dma_wdata = 32'(i);
            #1 gs[i] = dma_gnt;
            if (dma_gnt) g++;
            cyc();
        end
        chk32("cap_total", 32'(g), 32'd17);
        chk1("cap_first", gs[0], 1'b0);
        chk1("cap_beat8", gs[8], 1'b1);
        chk1("cap_gap", gs[9], 1'b0);
        chk1("cap_next", gs[10], 1'b1);
        chk1("cap_gap2", gs[18], 1'b0);
        idle();
        cyc(); cyc();

        // Reset on beat 3 of a burst (beat 2 is a read).
        dma_req = 1; dma_we = 1; dma_addr = 32'h200; dma_wdata = 32'h5;
        cyc();
        cyc();
        dma_we = 0; dma_addr = 32'h80;
        cyc();
        dma_we = 1; dma_addr = 32'h208; reset = 1;
        #1 chk1("rmb_we", mem_we, 1'b0);
        chk1("rmb_rv_before", dma_rvalid, 1'b1);
        cyc();
        reset = 0; idle();
        #1 chk1("rmb_gnt", dma_gnt, 1'b0);
        chk1("rmb_rv", dma_rvalid, 1'b0);
        cyc();

        // Randomized traffic with varying densities and rare resets.
        for (int seg = 0; seg < 6; seg++) begin
            dens_c = $urandom_range(0, 100);
            dens_d = $urandom_range(10, 100);
            for (int i = 0; i < 500; i++) begin
                reset         = ($urandom_range(0, 299) == 0);
                cpu_req       = ($urandom_range(0, 99) < dens_c);
                cpu_memwrite  = $urandom_range(0, 1) == 1;
                cpu_dataadr   = 32'($urandom_range(0, 31)) << 2;
                cpu_writedata = $urandom;
                dma_req       = ($urandom_range(0, 99) < dens_d);
                dma_we        = $urandom_range(0, 1) == 1;
                dma_addr      = 32'($urandom_range(0, 31)) << 2;
                dma_wdata     = $urandom;
                cyc();
            end
        end
        reset = 0; idle();
        cyc(); cyc();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
